// File: rtl/tm1638_responder.sv
// -----------------------------------------------------------------------------
// tm1638_responder
//
// Responder side of a TM1638-style three-wire serial bus (strobe / clock /
// bidirectional data). The block decodes data, display-control and
// address-set commands, stores written bytes in a 16 x 8 display RAM, exposes
// that RAM through a registered read port and, optionally, streams a 32-bit
// key-scan word back to the initiator.
//
// Optional feature macro:
//   TM1638_RESPONDER_KEYS_EN  - enables key read-back (DATA_RD state). When
//                               undefined, read commands fall into IGNORE, the
//                               data-out/oe outputs are tied low and keys is
//                               unused.
//
// Parameters:
//   SYNC_STAGES     synchronizer depth for the three serial inputs (2..3)
//
// Ports:
//   clk             system clock; every flop runs on it
//   n_rst           asynchronous active-low reset
//   tm1638_strobe   frame select, active low
//   tm1638_clk      serial clock, idles high, at most clk/8
//   tm1638_data_in  serial data from the initiator, LSB first
//   tm1638_data_out serial key data to the initiator
//   tm1638_data_oe  data-pin drive enable (pad tristate lives outside)
//   keys            key-scan bytes, byte0 = keys[7:0] sent first
//   ram_addr        display RAM read address
//   ram_data        display RAM read data, one cycle after ram_addr
//   display_on      display enable from the last display-control command
//   display_level   brightness from the last display-control command
//   frame_done      one-cycle pulse when a frame that wrote the RAM ends
//   cmd_err         one-cycle pulse on an undefined command byte
// -----------------------------------------------------------------------------
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        tm1638_strobe,
    input  logic        tm1638_clk,
    input  logic        tm1638_data_in,
    output logic        tm1638_data_out,
    output logic        tm1638_data_oe,
    input  logic [31:0] keys,
    input  logic [3:0]  ram_addr,
    output logic [7:0]  ram_data,
    output logic        display_on,
    output logic [2:0]  display_level,
    output logic        frame_done,
    output logic        cmd_err
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA_WR,
        DATA_RD,
        IGNORE
    } state_t;

    state_t state_q, state_d;

    // Synchronizers: the oldest sample (MSB) is the one the logic uses.
    logic [SYNC_STAGES-1:0] strb_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   strb_prev_q;
    logic                   sclk_prev_q;
    logic [1:0]             flush_q;
    logic                   armed_q;

    logic strb_cur, sclk_cur, din_cur;
    logic flushed;
    logic strb_fall, strb_rise, sclk_rise, sclk_fall;

    // Frame datapath
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [3:0] ptr_q;
    logic       fixed_q;
    logic       read_q;
    logic       wrote_q;
    logic [7:0] ram_q [16];
    logic [7:0] ram_data_q;
    logic       display_on_q;
    logic [2:0] display_level_q;
    logic       frame_done_q;
    logic       cmd_err_q;

    logic       shifting;
    logic       byte_done;
    logic [7:0] byte_w;

    logic cmd_data, cmd_disp, cmd_addr, cmd_bad, ram_we, rd_enter;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            strb_sync_q <= '1;
            sclk_sync_q <= '1;
            din_sync_q  <= '0;
            strb_prev_q <= 1'b1;
            sclk_prev_q <= 1'b1;
            flush_q     <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            strb_sync_q <= {strb_sync_q[SYNC_STAGES-2:0], tm1638_strobe};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], tm1638_clk};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], tm1638_data_in};
            strb_prev_q <= strb_cur;
            sclk_prev_q <= sclk_cur;
            if (!flushed) begin
                flush_q <= flush_q + 2'd1;
            end
            // A strobe that was already low across reset must go high before
            // a new frame may start, so a half-finished frame is never resumed.
            if (flushed && strb_cur) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign strb_cur = strb_sync_q[SYNC_STAGES-1];
    assign sclk_cur = sclk_sync_q[SYNC_STAGES-1];
    assign din_cur  = din_sync_q[SYNC_STAGES-1];
    assign flushed  = (flush_q == 2'(SYNC_STAGES));

    assign strb_fall = armed_q & strb_prev_q & ~strb_cur;
    assign strb_rise = ~strb_prev_q & strb_cur;
    // Serial clock edges only count inside a frame (strobe low).
    assign sclk_rise = ~strb_cur & ~strb_fall & ~sclk_prev_q & sclk_cur;
    assign sclk_fall = ~strb_cur & ~strb_fall & sclk_prev_q & ~sclk_cur;

    assign shifting  = sclk_rise &
                       ((state_q == CMD) || (state_q == DATA_WR) || (state_q == IGNORE));
    assign byte_w    = {din_cur, shift_q[7:1]};
    assign byte_done = shifting & (bit_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_data = 1'b0;
        cmd_disp = 1'b0;
        cmd_addr = 1'b0;
        cmd_bad  = 1'b0;
        ram_we   = 1'b0;
        rd_enter = 1'b0;
        if (strb_rise) begin
            state_d = IDLE;
        end else if (strb_fall) begin
            state_d = CMD;
        end else if (byte_done) begin
            unique case (state_q)
                CMD: begin
                    unique case (byte_w[7:6])
                        2'b01: begin
                            cmd_data = 1'b1;
                            state_d  = IGNORE;
`ifdef TM1638_RESPONDER_KEYS_EN
                            if (byte_w[1]) begin
                                rd_enter = 1'b1;
                                state_d  = DATA_RD;
                            end
`endif
                        end
                        2'b10: begin
                            cmd_disp = 1'b1;
                            state_d  = IGNORE;
                        end
                        2'b11: begin
                            cmd_addr = 1'b1;
                            state_d  = DATA_WR;
                        end
                        default: begin
                            cmd_bad = 1'b1;
                            state_d = IGNORE;
                        end
                    endcase
                end
                DATA_WR: ram_we = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt_q       <= 3'd0;
            shift_q         <= 8'd0;
            ptr_q           <= 4'd0;
            fixed_q         <= 1'b0;
            read_q          <= 1'b0;
            wrote_q         <= 1'b0;
            ram_data_q      <= 8'd0;
            display_on_q    <= 1'b0;
            display_level_q <= 3'd0;
            frame_done_q    <= 1'b0;
            cmd_err_q       <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                ram_q[i] <= 8'd0;
            end
        end else begin
            frame_done_q <= strb_rise & wrote_q;
            cmd_err_q    <= cmd_bad;

            // A partial byte is simply dropped: the counter restarts at the
            // next strobe fall.
            if (strb_fall || strb_rise) begin
                bit_cnt_q <= 3'd0;
                shift_q   <= 8'd0;
                wrote_q   <= 1'b0;
            end else if (shifting) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shift_q   <= byte_w;
            end

            if (cmd_data) begin
                fixed_q <= byte_w[2];
                read_q  <= byte_w[1];
            end
            if (cmd_disp) begin
                display_on_q    <= byte_w[3];
                display_level_q <= byte_w[2:0];
            end

            if (cmd_addr) begin
                ptr_q <= byte_w[3:0];
            end else if (ram_we && !fixed_q) begin
                ptr_q <= ptr_q + 4'd1;
            end

            if (ram_we) begin
                ram_q[ptr_q] <= byte_w;
                wrote_q      <= 1'b1;
            end

            // Reads the pre-write contents when a write hits the same address.
            ram_data_q <= ram_q[ram_addr];
        end
    end

    assign ram_data      = ram_data_q;
    assign display_on    = display_on_q;
    assign display_level = display_level_q;
    assign frame_done    = frame_done_q;
    assign cmd_err       = cmd_err_q;

    // The read bit is retained as mode state; the read decision itself is
    // taken from the command byte as it completes.
    logic unused_read;
    assign unused_read = read_q;

`ifdef TM1638_RESPONDER_KEYS_EN
    logic [31:0] keys_lat_q;
    logic [5:0]  rp_q;
    logic        dout_q;
    logic        oe_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            keys_lat_q <= 32'd0;
            rp_q       <= 6'd0;
            dout_q     <= 1'b0;
            oe_q       <= 1'b0;
        end else if (strb_rise || strb_fall) begin
            oe_q   <= 1'b0;
            dout_q <= 1'b0;
        end else if (rd_enter) begin
            keys_lat_q <= keys;
            rp_q       <= 6'd0;
            oe_q       <= 1'b1;
            dout_q     <= keys[0];
        end else if (state_q == DATA_RD) begin
            if (sclk_rise && !rp_q[5]) begin
                rp_q <= rp_q + 6'd1;
            end
            if (sclk_fall) begin
                dout_q <= rp_q[5] ? 1'b0 : keys_lat_q[rp_q[4:0]];
            end
        end
    end

    // Drop the driver in the very cycle the strobe rise is seen.
    assign tm1638_data_oe  = oe_q & ~strb_rise;
    assign tm1638_data_out = dout_q;
`else
    assign tm1638_data_oe  = 1'b0;
    assign tm1638_data_out = 1'b0;

    logic unused_keys;
    assign unused_keys = ^{keys, sclk_fall, rd_enter};
`endif

endmodule

// File: tb/tb_tm1638_responder.sv
`timescale 1ns/1ps
module tb_tm1638_responder;

    localparam int HALF    = 8;   // system clocks per serial half period
    localparam int K_RAM   = 0;
    localparam int K_DISP  = 1;
    localparam int K_OE    = 2;
    localparam int K_PULSE = 3;

    typedef struct {
        int         kind;
        logic [7:0] val;
        string      name;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        strobe;
    logic        sclk;
    logic        din;
    logic        dout;
    logic        oe;
    logic [31:0] keys;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_data;
    logic        disp_on;
    logic [2:0]  disp_lvl;
    logic        frame_done;
    logic        cmd_err;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic req_vld  = 1'b0;
    int   req_kind = 0;
    logic mon_vld  = 1'b0;
    int   mon_kind = 0;

    always #5 clk = ~clk;

    tm1638_responder #(.SYNC_STAGES(2)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .tm1638_strobe   (strobe),
        .tm1638_clk      (sclk),
        .tm1638_data_in  (din),
        .tm1638_data_out (dout),
        .tm1638_data_oe  (oe),
        .keys            (keys),
        .ram_addr        (ram_addr),
        .ram_data        (ram_data),
        .display_on      (disp_on),
        .display_level   (disp_lvl),
        .frame_done      (frame_done),
        .cmd_err         (cmd_err)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(posedge clk) begin
        mon_vld  <= req_vld;
        mon_kind <= req_kind;
    end

    task automatic pop_cmp(input int kind);
        exp_t       e;
        logic [7:0] act;
        case (kind)
            K_RAM:   act = ram_data;
            K_DISP:  act = {4'b0, disp_on, disp_lvl};
            K_OE:    act = {6'b0, oe, dout};
            default: act = {6'b0, frame_done, cmd_err};
        endcase
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d value %0h, expected no event", kind, act);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind) begin
                checks++;
                errors++;
                $display("FAIL %s: got event kind %0d value %0h, expected kind %0d value %0h",
                         e.name, kind, act, e.kind, e.val);
            end else begin
                chk(e.name, {24'd0, act}, {24'd0, e.val});
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_vld) pop_cmp(mon_kind);
            if (frame_done === 1'b1 || cmd_err === 1'b1) pop_cmp(K_PULSE);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_evt(input int kind, input logic [7:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic request(input int kind, input logic [7:0] val, input string name);
        @(negedge clk);
        expect_evt(kind, val, name);
        req_kind = kind;
        req_vld  = 1'b1;
        @(negedge clk);
        req_vld  = 1'b0;
    endtask

    task automatic check_ram(input logic [3:0] addr, input logic [7:0] val, input string name);
        @(negedge clk);
        ram_addr = addr;
        request(K_RAM, val, name);
    endtask

    task automatic send_bit(input logic b);
        sclk = 1'b0;
        din  = b;
        wait_clk(HALF);
        sclk = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic frame_begin();
        strobe = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end();
        wait_clk(HALF);
        strobe = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic one_byte_frame(input logic [7:0] b);
        frame_begin();
        send_byte(b);
        frame_end();
    endtask

    // Initiator read slot: the bench samples {oe, data_out} late in the low
    // phase, i.e. what the initiator would latch at the following rise.
    task automatic read_bit(input logic [1:0] exp, input string name);
        sclk = 1'b0;
        wait_clk(4);
        request(K_OE, {6'b0, exp}, name);
        wait_clk(2);
        sclk = 1'b1;
        wait_clk(HALF);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no end of stimulus, expected completion within 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] kv;
        n_rst    = 1'b0;
        strobe   = 1'b1;
        sclk     = 1'b1;
        din      = 1'b0;
        keys     = 32'h0;
        ram_addr = 4'd0;
        wait_clk(5);

        // Reset state
        chk("rst_data_out", {31'd0, dout}, 32'd0);
        chk("rst_data_oe", {31'd0, oe}, 32'd0);
        chk("rst_ram_data", {24'd0, ram_data}, 32'd0);
        chk("rst_display_on", {31'd0, disp_on}, 32'd0);
        chk("rst_display_level", {29'd0, disp_lvl}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        n_rst = 1'b1;
        wait_clk(10);

        // Sequential write of three bytes from address 0
        one_byte_frame(8'h40);
        expect_evt(K_PULSE, 8'h02, "seq_frame_done");
        frame_begin();
        send_byte(8'hC0);
        send_byte(8'h3F);
        send_byte(8'h06);
        send_byte(8'h5B);
        frame_end();
        check_ram(4'd0, 8'h3F, "seq_ram0");
        check_ram(4'd1, 8'h06, "seq_ram1");
        check_ram(4'd2, 8'h5B, "seq_ram2");
        check_ram(4'd3, 8'h00, "seq_ram3_untouched");

        // Fixed-address mode overwrites the same location
        one_byte_frame(8'h44);
        expect_evt(K_PULSE, 8'h02, "fixed_frame_done");
        frame_begin();
        send_byte(8'hC5);
        send_byte(8'h11);
        send_byte(8'h22);
        frame_end();
        check_ram(4'd5, 8'h22, "fixed_ram5");
        check_ram(4'd6, 8'h00, "fixed_ram6_untouched");

        // Auto-increment wraps from 15 to 0
        one_byte_frame(8'h40);
        expect_evt(K_PULSE, 8'h02, "wrap_frame_done");
        frame_begin();
        send_byte(8'hCF);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        frame_end();
        check_ram(4'd15, 8'hAA, "wrap_ram15");
        check_ram(4'd0, 8'hBB, "wrap_ram0");
        check_ram(4'd1, 8'hCC, "wrap_ram1");
        check_ram(4'd2, 8'h5B, "wrap_ram2_kept");

        // Partial trailing byte is dropped
        expect_evt(K_PULSE, 8'h02, "partial_frame_done");
        frame_begin();
        send_byte(8'hC4);
        send_byte(8'h12);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        frame_end();
        check_ram(4'd4, 8'h12, "partial_ram4");
        check_ram(4'd5, 8'h22, "partial_ram5_kept");

        // Display control, no frame_done
        one_byte_frame(8'h8C);
        request(K_DISP, 8'h0C, "display_ctrl");

        // Undefined command: cmd_err pulse, following byte ignored
        expect_evt(K_PULSE, 8'h01, "cmd_err_pulse");
        frame_begin();
        send_byte(8'h00);
        send_byte(8'hC7);
        frame_end();
        check_ram(4'd7, 8'h00, "cmd_err_no_write");

        // Key read-back
        kv   = 32'h80_01_F0_A5;
        keys = kv;
        frame_begin();
        send_byte(8'h42);
`ifdef TM1638_RESPONDER_KEYS_EN
        for (int i = 0; i < 32; i++) read_bit({1'b1, kv[i]}, $sformatf("key_bit%0d", i));
        read_bit(2'b10, "key_after_32");
`else
        for (int i = 0; i < 8; i++) read_bit(2'b00, $sformatf("key_off_bit%0d", i));
`endif
        frame_end();
        request(K_OE, 8'h00, "oe_after_strobe_rise");
        keys = 32'h0;

        // Reset in the middle of an address-set command
        ram_addr = 4'd0;
        frame_begin();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        sclk = 1'b0;
        wait_clk(2);
        n_rst = 1'b0;
        wait_clk(3);
        chk("midrst_data_oe", {31'd0, oe}, 32'd0);
        chk("midrst_data_out", {31'd0, dout}, 32'd0);
        chk("midrst_ram_data", {24'd0, ram_data}, 32'd0);
        chk("midrst_display_on", {31'd0, disp_on}, 32'd0);
        chk("midrst_display_level", {29'd0, disp_lvl}, 32'd0);
        n_rst = 1'b1;
        wait_clk(4);
        for (int i = 3; i < 8; i++) send_bit(i >= 6);
        send_byte(8'h99);
        frame_end();
        check_ram(4'd0, 8'h00, "midrst_ram0");
        check_ram(4'd1, 8'h00, "midrst_ram1");
        request(K_DISP, 8'h00, "midrst_display");

        // Normal operation resumes with the next frame
        expect_evt(K_PULSE, 8'h02, "post_rst_frame_done");
        frame_begin();
        send_byte(8'hC3);
        send_byte(8'h77);
        frame_end();
        check_ram(4'd3, 8'h77, "post_rst_ram3");
        check_ram(4'd4, 8'h00, "post_rst_ram4");

        wait_clk(20);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: got no event, expected kind %0d value %0h", e.name, e.kind, e.val);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tm1638_responder.md
TM1638_RESPONDER -- requirements
Module: tm1638_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth (range 2..3) for tm1638_strobe, tm1638_clk and tm1638_data_in.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; every flop is clocked by it.
REQ-003 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port tm1638_strobe, input, 1 bit: frame select, active low.
REQ-005 SHALL have port tm1638_clk, input, 1 bit: serial clock, idle high.
REQ-006 SHALL have port tm1638_data_in, input, 1 bit: serial data from the initiator, LSB first.
REQ-007 SHALL have port tm1638_data_out, output, 1 bit: serial key data to the initiator.
REQ-008 SHALL have port tm1638_data_oe, output, 1 bit: data-pin drive enable; the pad tristate sits outside this block.
REQ-009 SHALL have port keys, input, 32 bits: key-scan bytes; byte0 = keys[7:0], sent first.
REQ-010 SHALL have port ram_addr, input, 4 bits: display RAM read address.
REQ-011 SHALL have port ram_data, output, 8 bits: registered display RAM read data.
REQ-012 SHALL have port display_on, output, 1 bit: display enable from the last display-control command.
REQ-013 SHALL have port display_level, output, 3 bits: brightness from the last display-control command.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame that wrote the RAM ends.
REQ-015 SHALL have port cmd_err, output, 1 bit: one-cycle pulse when an undefined command is received.

Function
REQ-016 SHALL pass all three serial inputs through SYNC_STAGES flops, then detect edges in the clk domain; tm1638_clk SHALL be at most clk/8.
REQ-017 SHALL use the FSM states IDLE, CMD, DATA_WR, DATA_RD and IGNORE.
REQ-018 SHALL, on a strobe falling edge in any state, enter CMD and clear the bit counter and shift register.
REQ-019 SHALL, on a strobe rising edge in any state, enter IDLE and deassert tm1638_data_oe in the same cycle.
REQ-020 SHALL ignore tm1638_clk edges while strobe is high.
REQ-021 SHALL, in CMD, DATA_WR and IGNORE, shift the data bit in on each tm1638_clk rising edge (LSB first) and complete a byte on the 8th edge.
REQ-022 SHALL decode a completed byte in CMD by bits[7:6]:
- 01 (data command): store fixed = bit2 and read = bit1; go to DATA_RD if read = 1, else IGNORE.
- 10 (display control): update display_on = bit3 and display_level = bits[2:0] one cycle later; go to IGNORE.
- 11 (address set): load the address pointer from bits[3:0]; go to DATA_WR.
- 00: pulse cmd_err; go to IGNORE.
REQ-023 SHALL, in DATA_WR, write each completed byte to ram[ptr]; if fixed = 0, ptr SHALL then increment, wrapping from 15 to 0.
REQ-024 SHALL, in DATA_WR, overwrite ram[ptr] repeatedly when fixed = 1.
REQ-025 SHALL, on entry to DATA_RD, latch keys, set the read pointer rp to 0, assert tm1638_data_oe and drive bit0.
REQ-026 SHALL, in DATA_RD, increment rp on each tm1638_clk rising edge, saturating at 32.
REQ-027 SHALL, in DATA_RD, update tm1638_data_out on each tm1638_clk falling edge to latched_keys[rp], or to 0 when rp = 32.
REQ-028 SHALL discard data bits while in IGNORE.
REQ-029 SHALL discard a partial byte (fewer than 8 bits) at a strobe rise.
REQ-030 SHALL pulse frame_done for one cycle on a strobe rise if at least one RAM write occurred in that frame.
REQ-031 SHALL register ram_data = ram[ram_addr] with 1-cycle latency.
REQ-032 SHALL let a same-cycle RAM write and read of the same address return the old value.
REQ-033 SHALL keep the fixed/read mode across frames until the next data command.

Reset
REQ-034 SHALL, on n_rst low, asynchronously set the state to IDLE and clear ram, ptr, rp, fixed, read and all synchronizers.
REQ-035 SHALL set the synchronizer flops for tm1638_strobe and tm1638_clk to 1 on reset.
REQ-036 SHALL reset outputs to tm1638_data_out = 0, tm1638_data_oe = 0, ram_data = 0, display_on = 0, display_level = 0, frame_done = 0 and cmd_err = 0.
REQ-037 SHALL abort a frame in progress when reset is asserted mid-frame; after release, bus edges SHALL be ignored until the next strobe falling edge.

Configuration
REQ-038 SHALL support key read-back when macro TM1638_RESPONDER_KEYS_EN is defined, per REQ-025 to REQ-027.
REQ-039 SHALL, when TM1638_RESPONDER_KEYS_EN is undefined, route a data command with read = 1 to IGNORE, tie tm1638_data_oe and tm1638_data_out to 0, and leave keys unused.

Verification
REQ-040 SHALL cover: frame 0x40, then frame 0xC0 + 0x3F 0x06 0x5B -> ram[0..2] = 3F, 06, 5B; one frame_done pulse.
REQ-041 SHALL cover: frame 0x44, then frame 0xC5 + 0x11 0x22 -> ram[5] = 22 and ram[6] unchanged.
REQ-042 SHALL cover: auto-increment write at 0xCF with 3 bytes AA BB CC -> ram[15] = AA, ram[0] = BB, ram[1] = CC.
REQ-043 SHALL cover: frame 0x8C -> display_on = 1 and display_level = 4, with no frame_done pulse.
REQ-044 SHALL cover (TM1638_RESPONDER_KEYS_EN defined): keys = 32'h80_01_F0_A5 and frame 0x42 with 32 read clocks -> bytes A5, F0, 01, 80 are sampled LSB first on rising edges; oe drops at strobe rise.
REQ-045 SHALL cover: 0x00 command -> cmd_err pulse; reset asserted after 3 bits of 0xC0 -> all outputs at reset values and no RAM write.
